float_act_pipe: RTL and testbench

- Streaming, multi-lane activation unit for float vectors.
- Successor to the single-word combinational ReLU, generalised in four ways:
  - LANES parallel float words per beat.
  - Runtime-selectable mode: pass, ReLU, leaky ReLU (power-of-two slope), clamped ReLU.
  - 2-stage registered pipeline with valid/ready backpressure.
  - Output beat counter.
- Sits between the matmul accumulator output and the result writeback.

---
 rtl/float_act_pipe_pkg.sv | 19 +
 rtl/float_act_lane.sv | 61 ++++++
 rtl/float_act_pipe.sv | 89 ++++++++
 tb/tb_float_act_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/float_act_pipe_pkg.sv
// Shared float/activation definitions for the float_act_pipe slice.
// Provides the default float field widths and the 2-bit activation mode codes.
package float_act_pipe_pkg;

  localparam int unsigned FLOAT_EXP_WIDTH  = 8;
  localparam int unsigned FLOAT_MANT_WIDTH = 23;

  typedef enum logic [1:0] {
    FLOAT_ACT_PASS  = 2'd0,
    FLOAT_ACT_RELU  = 2'd1,
    FLOAT_ACT_LEAKY = 2'd2,
    FLOAT_ACT_CLAMP = 2'd3
  } act_mode_e;

  function automatic int unsigned float_width(input int unsigned ew, input int unsigned mw);
    return 1 + ew + mw;
  endfunction

endpackage

// File: rtl/float_act_lane.sv
// Combinational activation for one float word.
// Ports:
//   x         in  float word {sign, exponent, mantissa}
//   mode      in  activation mode (act_mode_e encoding)
//   shift     in  leaky slope exponent, slope = 2^-shift
//   clamp_val in  non-negative upper bound for clamp mode
//   y         out activated word
module float_act_lane
  import float_act_pipe_pkg::*;
#(
  parameter int unsigned EXP_WIDTH   = FLOAT_EXP_WIDTH,
  parameter int unsigned MANT_WIDTH  = FLOAT_MANT_WIDTH,
  parameter int unsigned SHIFT_WIDTH = 3,
  localparam int unsigned FW = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic [FW-1:0]          x,
  input  logic [1:0]             mode,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [FW-1:0]          clamp_val,
  output logic [FW-1:0]          y
);

  // Exponent and shift compared at a common width so any SHIFT_WIDTH works.
  localparam int unsigned CW = EXP_WIDTH + SHIFT_WIDTH;

  logic                  sgn;
  logic [EXP_WIDTH-1:0]  e;
  logic [MANT_WIDTH-1:0] m;
  logic [CW-1:0]         e_w;
  logic [CW-1:0]         sh_w;

  assign sgn  = x[FW-1];
  assign e    = x[FW-2 -: EXP_WIDTH];
  assign m    = x[MANT_WIDTH-1:0];
  assign e_w  = CW'(e);
  assign sh_w = CW'(shift);

  always_comb begin
    y = x;
    case (mode)
      FLOAT_ACT_PASS: y = x;
      FLOAT_ACT_RELU: begin
        if (sgn) y = '0;
      end
      FLOAT_ACT_LEAKY: begin
        // Negative finite values are scaled by decrementing the exponent;
        // anything that would become denormal or zero is flushed.
        if (sgn && (shift != '0) && (e != '1)) begin
          if (e_w > sh_w) y = {1'b1, EXP_WIDTH'(e_w - sh_w), m};
          else            y = '0;
        end
      end
      FLOAT_ACT_CLAMP: begin
        if (sgn)                                y = '0;
        else if (x[FW-2:0] > clamp_val[FW-2:0]) y = clamp_val;
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/float_act_pipe.sv
// Streaming multi-lane float activation unit with a 2-stage pipeline.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   mode/shift/clamp_val  per-beat configuration, captured with the beat
//   in_valid/in_ready/in_data     input stream, lane i at [i*FW +: FW]
//   out_valid/out_ready/out_data  output stream, same packing
//   count      output handshakes since reset, wrapping
module float_act_pipe
  import float_act_pipe_pkg::*;
#(
  parameter int unsigned EXP_WIDTH   = FLOAT_EXP_WIDTH,
  parameter int unsigned MANT_WIDTH  = FLOAT_MANT_WIDTH,
  parameter int unsigned LANES       = 4,
  parameter int unsigned SHIFT_WIDTH = 3,
  parameter int unsigned COUNT_WIDTH = 16,
  localparam int unsigned FW = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [FW-1:0]          clamp_val,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*FW-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*FW-1:0]    out_data,
  output logic [COUNT_WIDTH-1:0] count
);

  logic                   advance;
  logic                   s1_valid;
  logic [LANES*FW-1:0]    s1_data;
  logic [1:0]             s1_mode;
  logic [SHIFT_WIDTH-1:0] s1_shift;
  logic [FW-1:0]          s1_clamp;
  logic [LANES*FW-1:0]    lane_y;

  // Whole pipe moves together; an empty output slot always lets it move.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
      s1_shift <= '0;
      s1_clamp <= '0;
    end else if (advance) begin
      s1_valid <= in_valid && in_ready;
      s1_data  <= in_data;
      s1_mode  <= mode;
      s1_shift <= shift;
      s1_clamp <= clamp_val;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    float_act_lane #(
      .EXP_WIDTH  (EXP_WIDTH),
      .MANT_WIDTH (MANT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .x        (s1_data[i*FW +: FW]),
      .mode     (s1_mode),
      .shift    (s1_shift),
      .clamp_val(s1_clamp),
      .y        (lane_y[i*FW +: FW])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_data  <= lane_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         count <= '0;
    else if (out_valid && out_ready) count <= count + 1'b1;
  end

endmodule

// File: tb/tb_float_act_pipe.sv
module tb_float_act_pipe;

  localparam int FW = 32;
  localparam int DW = 4 * FW;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [2:0]    shift;
  logic [31:0]   clamp_val;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [15:0]   count;

  float_act_pipe #(
    .EXP_WIDTH  (8),
    .MANT_WIDTH (23),
    .LANES      (4),
    .SHIFT_WIDTH(3),
    .COUNT_WIDTH(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .shift    (shift),
    .clamp_val(clamp_val),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  int            passed = 0;
  int            total  = 0;
  int            failed = 0;
  logic [DW-1:0] q_exp[$];
  logic [15:0]   cnt_model = '0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          last_ih = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Reference: numeric reading of each mode on IEEE single fields.
  function automatic logic [31:0] ref_word(input logic [31:0] x, input int md, input int sh,
                                           input logic [31:0] cl);
    bit          neg = x[31];
    int          ex  = int'(x[30:23]);
    int unsigned mag = x[30:0];
    int unsigned lim = cl[30:0];
    logic [7:0]  ne;
    case (md)
      1: return neg ? 32'h0 : x;
      2: begin
        if (!neg || sh == 0 || ex == 255) return x;
        if (ex - sh >= 1) begin
          ne = 8'(ex - sh);
          return {1'b1, ne, x[22:0]};
        end
        return 32'h0;
      end
      3: begin
        if (neg) return 32'h0;
        return (mag > lim) ? cl : x;
      end
      default: return x;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input int md, input int sh,
                                             input logic [31:0] cl);
    logic [DW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*FW +: FW] = ref_word(d[i*FW +: FW], md, sh, cl);
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0] e;
    case ($urandom % 6)
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 8));
      default: e = 8'($urandom);
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // One clock: observe handshakes just before the edge, then check count after it.
  task automatic cycle();
    logic ih, oh;
    #1;
    ih = in_valid && in_ready;
    oh = out_valid && out_ready;
    if (stall_prev) begin
      chk("stall_valid", DW'(out_valid), DW'(1));
      chk("stall_data", out_data, stall_data);
    end
    if (oh) begin
      if (q_exp.size() == 0) chk("spurious_output", DW'(q_exp.size()), DW'(1));
      else                   chk("lane_data", out_data, q_exp.pop_front());
      cnt_model = cnt_model + 16'd1;
    end
    if (ih) q_exp.push_back(ref_beat(in_data, int'(mode), int'(shift), clamp_val));
    last_ih    = ih;
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    @(posedge clk);
    #1;
    chk("count", DW'(count), DW'(cnt_model));
  endtask

  initial begin
    int sent;
    logic [15:0] base;
    logic [DW-1:0] neg_beat;

    rst = 1'b1; mode = 2'd0; shift = 3'd0; clamp_val = 32'h0;
    in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", DW'(out_valid), DW'(0));
    chk("reset_out_data", out_data, DW'(0));
    chk("reset_count", DW'(count), DW'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_reset", DW'(in_ready), DW'(1));

    // RELU directed beat
    mode = 2'd1; in_valid = 1'b1;
    in_data = pack4(32'h3F800000, 32'hC0000000, 32'h80000000, 32'h7F800000);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("relu_valid", DW'(out_valid), DW'(1));
    chk("relu_data", out_data, pack4(32'h3F800000, 32'h0, 32'h0, 32'h7F800000));
    cycle();
    chk("relu_count", DW'(count), DW'(1));

    // LEAKY directed beat
    mode = 2'd2; shift = 3'd3; in_valid = 1'b1;
    in_data = pack4(32'hC0000000, 32'h80800000, 32'hFF800000, 32'h40400000);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("leaky_data", out_data, pack4(32'hBE800000, 32'h0, 32'hFF800000, 32'h40400000));
    cycle();

    // CLAMP directed beat
    mode = 2'd3; clamp_val = 32'h40C00000; in_valid = 1'b1;
    in_data = pack4(32'h40F00000, 32'h40A00000, 32'hBF800000, 32'h7FC00000);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("clamp_data", out_data, pack4(32'h40C00000, 32'h40A00000, 32'h0, 32'h40C00000));
    cycle();

    // Backpressure: 5 beats, out_ready low for 3 cycles mid-stream
    base = count; sent = 0; mode = 2'd2; shift = 3'd1;
    in_data = pack4(rand_word(), rand_word(), rand_word(), rand_word());
    for (int i = 0; i < 14; i++) begin
      in_valid  = (sent < 5);
      out_ready = !(i >= 3 && i < 6);
      cycle();
      if (last_ih) begin
        sent++;
        in_data = pack4(rand_word(), rand_word(), rand_word(), rand_word());
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", DW'(sent), DW'(5));
    chk("bp_count", DW'(count - base), DW'(5));
    chk("bp_drained", DW'(q_exp.size()), DW'(0));

    // Config isolation: RELU beat followed by PASS beat with identical data
    neg_beat = pack4(32'hBF800000, 32'h3F800000, 32'hC1200000, 32'h80000001);
    mode = 2'd1; in_valid = 1'b1; in_data = neg_beat;
    cycle();
    mode = 2'd0;
    cycle();
    in_valid = 1'b0;
    chk("iso_relu_beat", out_data, pack4(32'h0, 32'h3F800000, 32'h0, 32'h0));
    cycle();
    chk("iso_pass_beat", out_data, neg_beat);
    cycle();

    // Reset with two beats in flight
    mode = 2'd0; in_valid = 1'b1; in_data = pack4(rand_word(), rand_word(), rand_word(), rand_word());
    cycle();
    in_data = pack4(rand_word(), rand_word(), rand_word(), rand_word());
    cycle();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", DW'(out_valid), DW'(0));
    chk("midrst_count", DW'(count), DW'(0));
    q_exp.delete(); cnt_model = '0; stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 2'd1; in_valid = 1'b1;
    in_data = pack4(32'h40000000, 32'hC0000000, 32'h00000001, 32'hFFC00000);
    cycle();
    in_valid = 1'b0;
    chk("postrst_empty", DW'(out_valid), DW'(0));
    cycle();
    chk("postrst_valid", DW'(out_valid), DW'(1));
    chk("postrst_data", out_data, pack4(32'h40000000, 32'h0, 32'h00000001, 32'h0));
    cycle();
    chk("postrst_count", DW'(count), DW'(1));

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      mode      = 2'($urandom);
      shift     = 3'($urandom);
      clamp_val = {1'b0, 31'($urandom)};
      in_data   = pack4(rand_word(), rand_word(), rand_word(), rand_word());
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_drained", DW'(q_exp.size()), DW'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
